// File: rtl/dmfb_train_pkg.sv
// Shared types and default sizing for the DMFB train-transport blocks.
package dmfb_train_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

  localparam int unsigned DEF_N_ELEC  = 10;
  localparam int unsigned DEF_MAX_LEN = 4;
  localparam int unsigned DEF_DWELL_W = 16;

endpackage

// File: rtl/dmfb_train_mask.sv
// Combinational (pos, len) -> electrode pattern; bits past the row end fold back
// to the start when DMFB_TRAIN_WRAP_EN is defined, otherwise they are dropped.
module dmfb_train_mask #(
  parameter int unsigned N_ELEC  = 10,
  parameter int unsigned MAX_LEN = 4,
  parameter int unsigned POS_W   = $clog2(N_ELEC),
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [POS_W-1:0]  pos,
  input  logic [LEN_W-1:0]  len,
  output logic [N_ELEC-1:0] pattern_c
);

  localparam int unsigned WIDE_W = N_ELEC + MAX_LEN;

  logic [WIDE_W-1:0] ones;
  logic [WIDE_W-1:0] wide;

  assign ones = (WIDE_W'(1) << len) - WIDE_W'(1);
  assign wide = ones << pos;

`ifdef DMFB_TRAIN_WRAP_EN
  // len <= N_ELEC keeps the spill below 2*N_ELEC, so one fold suffices
  assign pattern_c = wide[N_ELEC-1:0] | N_ELEC'(wide[WIDE_W-1:N_ELEC]);
`else
  logic [MAX_LEN-1:0] unused_spill;
  assign unused_spill = wide[WIDE_W-1:N_ELEC];
  assign pattern_c    = wide[N_ELEC-1:0];
`endif

endmodule

// File: rtl/dmfb_train_pattern_gen.sv
// Self-timed train move engine: steps a contiguous energised train from start_pos
// to target_pos one electrode per dwell. Ring track when DMFB_TRAIN_WRAP_EN is defined.
module dmfb_train_pattern_gen
  import dmfb_train_pkg::*;
#(
  parameter int unsigned N_ELEC  = DEF_N_ELEC,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned DWELL_W = DEF_DWELL_W,
  parameter int unsigned POS_W   = $clog2(N_ELEC),
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               act,
  input  logic               start,
  input  logic               clear,
  input  logic [POS_W-1:0]   start_pos,
  input  logic [POS_W-1:0]   target_pos,
  input  logic [LEN_W-1:0]   train_len,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               dir,
  output logic [N_ELEC-1:0]  disp,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d, tgt_q, tgt_d, step_pos;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [DWELL_W-1:0]   rl_q, rl_d, cnt_q, cnt_d, reload;
  logic                 vis_q, vis_d;
  logic                 dir_q, dir_d;
  logic                 busy_d, done_d, err_d, start_ok;
  logic [N_ELEC-1:0]    disp_d, pattern_c;

  dmfb_train_mask #(
    .N_ELEC (N_ELEC),
    .MAX_LEN(MAX_LEN),
    .POS_W  (POS_W),
    .LEN_W  (LEN_W)
  ) u_mask (
    .pos      (pos_d),
    .len      (len_d),
    .pattern_c(pattern_c)
  );

  // One electrode toward the target
`ifdef DMFB_TRAIN_WRAP_EN
  always_comb begin
    if (dir_q) step_pos = (pos_q == POS_W'(N_ELEC - 1)) ? '0 : pos_q + POS_W'(1);
    else       step_pos = (pos_q == '0) ? POS_W'(N_ELEC - 1) : pos_q - POS_W'(1);
  end
`else
  logic unused_dir;
  assign unused_dir = dir ^ dir_q;
  always_comb begin
    step_pos = (tgt_q > pos_q) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  end
`endif

  assign reload   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign start_ok = (int'(start_pos) < int'(N_ELEC)) && (int'(target_pos) < int'(N_ELEC)) &&
                    (train_len != '0) && (int'(train_len) <= int'(MAX_LEN));

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    len_d   = len_q;
    rl_d    = rl_q;
    cnt_d   = cnt_q;
    vis_d   = vis_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          vis_d = 1'b0;
        end else if (start) begin
          if (start_ok) begin
            state_d = MOVE;
            pos_d   = start_pos;
            tgt_d   = target_pos;
            len_d   = train_len;
            rl_d    = reload;
            cnt_d   = reload;
            dir_d   = dir;
            vis_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MOVE: begin
        if (clear) begin
          state_d = IDLE;
          vis_d   = 1'b0;
        end else if (act) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (pos_q == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            pos_d = step_pos;
            cnt_d = rl_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MOVE);
  end

  assign disp_d = (vis_d && act) ? pattern_c : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      tgt_q   <= '0;
      len_q   <= '0;
      rl_q    <= '0;
      cnt_q   <= '0;
      vis_q   <= 1'b0;
      dir_q   <= 1'b0;
      disp    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      len_q   <= len_d;
      rl_q    <= rl_d;
      cnt_q   <= cnt_d;
      vis_q   <= vis_d;
      dir_q   <= dir_d;
      disp    <= disp_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_dmfb_train_pattern_gen.sv
// Directed self-checking bench for dmfb_train_pattern_gen (N_ELEC=10, MAX_LEN=4).
module tb_dmfb_train_pattern_gen;

  logic        clock, reset_n, act, start, clear, dir;
  logic [3:0]  start_pos, target_pos;
  logic [2:0]  train_len;
  logic [15:0] dwell;
  logic [9:0]  disp;
  logic        busy, done, err;

  int errors = 0;
  int checks = 0;

  logic [9:0] fwd_tab [7] = '{10'h00F, 10'h01E, 10'h03C, 10'h078, 10'h0F0, 10'h1E0, 10'h3C0};
  logic [9:0] rev_tab [9] = '{10'h300, 10'h180, 10'h0C0, 10'h060, 10'h030,
                              10'h018, 10'h00C, 10'h006, 10'h003};

  dmfb_train_pattern_gen dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .act       (act),
    .start     (start),
    .clear     (clear),
    .start_pos (start_pos),
    .target_pos(target_pos),
    .train_len (train_len),
    .dwell     (dwell),
    .dir       (dir),
    .disp      (disp),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic [9:0] d, input logic b,
                         input logic dn, input logic e);
    chk({tag, ".disp"}, 32'(disp), 32'(d));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".err"},  32'(err),  32'(e));
  endtask

  task automatic do_start(input logic [3:0] sp, input logic [3:0] tp,
                          input logic [2:0] ln, input logic [15:0] dw, input logic dr);
    start_pos = sp; target_pos = tp; train_len = ln; dwell = dw; dir = dr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; act = 1'b1; start = 1'b0; clear = 1'b0; dir = 1'b0;
    start_pos = '0; target_pos = '0; train_len = '0; dwell = '0;
    #2;
    chk_out("reset", 10'h000, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Forward move: len 4, 0 -> 6, dwell 2
    do_start(4'd0, 4'd6, 3'd4, 16'd2, 1'b0);
    for (int c = 0; c < 14; c++) begin
      chk("fwd.disp", 32'(disp), 32'(fwd_tab[c/2]));
      chk("fwd.busy", 32'(busy), 32'd1);
      chk("fwd.done", 32'(done), 32'd0);
      tick();
    end
    chk_out("fwd.end", 10'h3C0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("fwd.hold", 10'h3C0, 1'b0, 1'b0, 1'b0);

    // Reverse move: len 2, 8 -> 0, dwell 1, act low for 3 cycles after position 3
    do_start(4'd8, 4'd0, 3'd2, 16'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_out("rev.pre", rev_tab[i], 1'b1, 1'b0, 1'b0);
      if (i < 3) tick();
    end
    act = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rev.pause", 10'h000, 1'b1, 1'b0, 1'b0);
    end
    act = 1'b1;
    for (int i = 4; i < 9; i++) begin
      tick();
      chk_out("rev.post", rev_tab[i], 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_out("rev.end", 10'h003, 1'b0, 1'b1, 1'b0);

    // Linear edge truncation: len 4, 8 -> 9
    do_start(4'd8, 4'd9, 3'd4, 16'd1, 1'b0);
    chk_out("trunc.0", 10'h300, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("trunc.1", 10'h200, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("trunc.end", 10'h200, 1'b0, 1'b1, 1'b0);

    // Invalid starts leave the pattern alone
    do_start(4'd10, 4'd2, 3'd2, 16'd1, 1'b0);
    chk_out("inv.pos", 10'h200, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("inv.after", 10'h200, 1'b0, 1'b0, 1'b0);
    do_start(4'd1, 4'd10, 3'd2, 16'd1, 1'b0);
    chk_out("inv.tgt", 10'h200, 1'b0, 1'b0, 1'b1);
    do_start(4'd1, 4'd2, 3'd0, 16'd1, 1'b0);
    chk_out("inv.len0", 10'h200, 1'b0, 1'b0, 1'b1);
    do_start(4'd1, 4'd2, 3'd5, 16'd1, 1'b0);
    chk_out("inv.len5", 10'h200, 1'b0, 1'b0, 1'b1);

    // Clear during a move
    do_start(4'd0, 4'd5, 3'd1, 16'd3, 1'b0);
    chk_out("clr.0", 10'h001, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_out("clr.hit", 10'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("clr.quiet", 10'h000, 1'b0, 1'b0, 1'b0);
    end

    // start == target with dwell 0 (treated as 1)
    do_start(4'd2, 4'd2, 3'd1, 16'd0, 1'b0);
    chk_out("same.0", 10'h004, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("same.end", 10'h004, 1'b0, 1'b1, 1'b0);

    // clear and start together in IDLE
    clear = 1'b1;
    do_start(4'd0, 4'd3, 3'd2, 16'd1, 1'b0);
    clear = 1'b0;
    chk_out("clrst.0", 10'h000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("clrst.1", 10'h000, 1'b0, 1'b0, 1'b0);

`ifdef DMFB_TRAIN_WRAP_EN
    // Ring: len 3, 8 -> 1, increasing
    do_start(4'd8, 4'd1, 3'd3, 16'd1, 1'b1);
    chk_out("wrap.0", 10'h301, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("wrap.1", 10'h203, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("wrap.2", 10'h007, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("wrap.3", 10'h00E, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("wrap.end", 10'h00E, 1'b0, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-move, then a fresh move
    do_start(4'd0, 4'd9, 3'd2, 16'd5, 1'b0);
    tick(); tick();
    chk_out("rst.pre", 10'h003, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_out("rst.async", 10'h000, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    do_start(4'd3, 4'd4, 3'd1, 16'd1, 1'b0);
    chk_out("rst.new0", 10'h008, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("rst.new1", 10'h010, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("rst.newend", 10'h010, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
